// File: rtl/otter_axil_pkg.sv
// -----------------------------------------------------------------------------
// otter_axil_pkg
// Shared definitions for the OTTER memory-port to AXI4-Lite bridge:
//   - state_t      : bridge FSM states
//   - SZ_*         : OTTER access-size encodings
//   - strb_gen     : byte-lane strobe for a given size/lane offset (8 lanes max)
//   - load_extend  : lane extraction plus sign/zero extension (64-bit max)
//   - misaligned   : natural-alignment check for a given size/lane offset
// All helpers work at the widest supported bus (64 bits / 8 lanes); callers
// truncate to their own DATA_WIDTH.
// -----------------------------------------------------------------------------
package otter_axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    // ((1 << 2^size) - 1) << off, computed at 8 lanes.
    function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] mask;
        case (size)
            SZ_BYTE: mask = 8'h01;
            SZ_HALF: mask = 8'h03;
            SZ_WORD: mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

    // Shift the addressed lanes down to bit 0, keep 8*2^size bits and
    // replicate the top kept bit when sign = 0 (sign = 1 means unsigned).
    function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                                input logic [2:0]  off,
                                                input logic [1:0]  size,
                                                input logic        sign);
        logic [63:0] t;
        logic [63:0] result;
        t = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: result = {{56{~sign & t[7]}},  t[7:0]};
            SZ_HALF: result = {{48{~sign & t[15]}}, t[15:0]};
            SZ_WORD: result = {{32{~sign & t[31]}}, t[31:0]};
            default: result = t;
        endcase
        return result;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off[1:0] != 2'b00);
            default: bad = (off != 3'b000);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/otter_axil_timeout.sv
// -----------------------------------------------------------------------------
// otter_axil_timeout
// Cycle counter that flags when a bus state has been occupied too long.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart counting from zero (takes priority over enable)
//   enable     : count this cycle
//   expired    : high in the cycle that completes LIMIT enabled cycles
// LIMIT = 0 removes the counter entirely and expired stays low.
// -----------------------------------------------------------------------------
module otter_axil_timeout #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (LIMIT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_counter
            // The count only ever reaches LIMIT-1, so $clog2(LIMIT) bits suffice.
            localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

            logic [CW-1:0] count_reg;

            // Expiry fires on the cycle whose increment would reach LIMIT, so
            // the owning state is occupied for exactly LIMIT cycles.
            assign expired = enable && (count_reg == CW'(LIMIT - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (enable && !expired) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/otter_axil_bridge.sv
// -----------------------------------------------------------------------------
// otter_axil_bridge
// Bridges an OTTER-style memory port to an AXI4-Lite controller port (no B
// channel). Stores are lane-aligned with generated strobes; loads are
// extracted from the addressed lanes and sign/zero extended. Misaligned or
// illegal-size requests and hung transactions report a one-cycle err pulse.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   addr, din                  byte address, right-aligned store data
//   memRead, memWrite          load / store request (store wins if both)
//   sign, size                 1 = unsigned load; 0/1/2/3 = byte/half/word/dword
//   dout, stall, err           load result, request pending, error pulse
//   araddr/arvalid/arready     AXI read address channel
//   rdata/rvalid/rready        AXI read data channel
//   awaddr/awvalid/awready     AXI write address channel
//   wdata/wvalid/wready/wstrb  AXI write data channel
// -----------------------------------------------------------------------------
module otter_axil_bridge
    import otter_axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    memRead,
    input  logic                    memWrite,
    input  logic                    sign,
    input  logic [1:0]              size,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    stall,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH/8-1:0] wstrb
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("otter_axil_bridge: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [OFF_W-1:0]        off_reg;
    logic [DATA_WIDTH-1:0]   din_reg;
    logic [1:0]              size_reg;
    logic                    sign_reg;
    logic                    aw_done_reg;
    logic                    w_done_reg;
    logic [DATA_WIDTH-1:0]   dout_reg;

    logic                    capture;
    logic                    tmo_clear;
    logic                    tmo_enable;
    logic                    tmo_expired;
    logic [OFF_W-1:0]        req_off;
    logic                    req_bad;
    logic [DATA_WIDTH-1:0]   load_data;

    assign req_off = addr[OFF_W-1:0];
    assign req_bad = misaligned(size, 3'(req_off)) ||
                     ((size == SZ_DWORD) && (DATA_WIDTH != 64));

    assign load_data = DATA_WIDTH'(load_extend(64'(rdata), 3'(off_reg), size_reg, sign_reg));

    assign araddr = addr_reg;
    assign awaddr = addr_reg;
    assign wdata  = din_reg << {off_reg, 3'b000};
    assign wstrb  = STRB_W'(strb_gen(size_reg, 3'(off_reg)));
    assign dout   = dout_reg;

    // Combinational so the core sees stall in the very cycle it raises a request.
    assign stall = (memRead || memWrite) &&
                   !((state_reg == ST_DONE) || (state_reg == ST_ERR));

    // The counter restarts on every entry into a bus state, including AR -> R.
    assign tmo_enable = (state_reg == ST_AR) || (state_reg == ST_R) || (state_reg == ST_WR);
    assign tmo_clear  = (state_next != state_reg) &&
                        ((state_next == ST_AR) || (state_next == ST_R) || (state_next == ST_WR));

    otter_axil_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        err        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (memRead || memWrite) begin
                    capture = 1'b1;
                    if (req_bad) begin
                        state_next = ST_ERR;
                    end else if (memWrite) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = ST_AR;
                    end
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (tmo_expired) begin
                    state_next = ST_ERR;
                end else if (arready) begin
                    state_next = ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                if (tmo_expired) begin
                    state_next = ST_ERR;
                end else if (rvalid) begin
                    state_next = ST_DONE;
                end
            end
            ST_WR: begin
                // Each valid stays up only until its own handshake.
                awvalid = !aw_done_reg;
                wvalid  = !w_done_reg;
                if (tmo_expired) begin
                    state_next = ST_ERR;
                end else if ((aw_done_reg || awready) && (w_done_reg || wready)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                err        = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            off_reg     <= '0;
            din_reg     <= '0;
            size_reg    <= SZ_BYTE;
            sign_reg    <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            dout_reg    <= '0;
        end else begin
            state_reg <= state_next;
            // Request fields are frozen here; later input changes are ignored.
            if (capture) begin
                addr_reg    <= {addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                off_reg     <= req_off;
                din_reg     <= din;
                size_reg    <= size;
                sign_reg    <= sign;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end
            if (awvalid && awready) begin
                aw_done_reg <= 1'b1;
            end
            if (wvalid && wready) begin
                w_done_reg <= 1'b1;
            end
            if (tmo_expired) begin
                dout_reg <= '0;
            end else if ((state_reg == ST_R) && rvalid) begin
                dout_reg <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_otter_axil_bridge.sv
// -----------------------------------------------------------------------------
// tb_otter_axil_bridge
// Directed bench: instance A is a 32-bit bridge with an 8-cycle timeout,
// instance B a 64-bit bridge with a 16-cycle timeout. One line is printed per
// transaction, then a single summary line.
// -----------------------------------------------------------------------------
module tb_otter_axil_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stall_cnt;
    int awv_cnt;

    // ---------------- instance A (32-bit) ----------------
    logic [31:0] a_addr = '0, a_din = '0, a_dout, a_araddr, a_rdata = '0, a_awaddr, a_wdata;
    logic        a_rd = 1'b0, a_wr = 1'b0, a_sign = 1'b0;
    logic [1:0]  a_size = 2'd0;
    logic        a_stall, a_err, a_arvalid, a_arready = 1'b0, a_rvalid = 1'b0, a_rready;
    logic        a_awvalid, a_awready = 1'b0, a_wvalid, a_wready = 1'b0;
    logic [3:0]  a_wstrb;

    otter_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut_a (
        .CLK(clk), .RST_N(rst_n), .addr(a_addr), .din(a_din),
        .memRead(a_rd), .memWrite(a_wr), .sign(a_sign), .size(a_size),
        .dout(a_dout), .stall(a_stall), .err(a_err),
        .araddr(a_araddr), .arvalid(a_arvalid), .arready(a_arready),
        .rdata(a_rdata), .rvalid(a_rvalid), .rready(a_rready),
        .awaddr(a_awaddr), .awvalid(a_awvalid), .awready(a_awready),
        .wdata(a_wdata), .wvalid(a_wvalid), .wready(a_wready), .wstrb(a_wstrb)
    );

    // ---------------- instance B (64-bit) ----------------
    logic [31:0] b_addr = '0, b_araddr, b_awaddr;
    logic [63:0] b_din = '0, b_dout, b_rdata = '0, b_wdata;
    logic        b_rd = 1'b0, b_wr = 1'b0, b_sign = 1'b0;
    logic [1:0]  b_size = 2'd0;
    logic        b_stall, b_err, b_arvalid, b_arready = 1'b0, b_rvalid = 1'b0, b_rready;
    logic        b_awvalid, b_awready = 1'b0, b_wvalid, b_wready = 1'b0;
    logic [7:0]  b_wstrb;

    otter_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(16)) dut_b (
        .CLK(clk), .RST_N(rst_n), .addr(b_addr), .din(b_din),
        .memRead(b_rd), .memWrite(b_wr), .sign(b_sign), .size(b_size),
        .dout(b_dout), .stall(b_stall), .err(b_err),
        .araddr(b_araddr), .arvalid(b_arvalid), .arready(b_arready),
        .rdata(b_rdata), .rvalid(b_rvalid), .rready(b_rready),
        .awaddr(b_awaddr), .awvalid(b_awvalid), .awready(b_awready),
        .wdata(b_wdata), .wvalid(b_wvalid), .wready(b_wready), .wstrb(b_wstrb)
    );

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load with zero-latency slave; returns in IDLE with dout settled.
    task automatic a_load(input string tag, input logic [31:0] ad, input logic [1:0] sz,
                          input logic sg, input logic [31:0] rd);
        int n;
        a_addr = ad; a_size = sz; a_sign = sg; a_rdata = rd;
        a_arready = 1'b1; a_rvalid = 1'b1; a_rd = 1'b1;
        #1;
        n = 0;
        while (a_stall && n < 20) begin
            step();
            n++;
        end
        chk1({tag, "_complete"}, a_stall, 1'b0);
        a_rd = 1'b0; a_arready = 1'b0; a_rvalid = 1'b0;
        step();
        $display("txn A load %s addr=%h dout=%h", tag, ad, a_dout);
    endtask

    task automatic b_load(input string tag, input logic [31:0] ad, input logic [1:0] sz,
                          input logic sg, input logic [63:0] rd);
        int n;
        b_addr = ad; b_size = sz; b_sign = sg; b_rdata = rd;
        b_arready = 1'b1; b_rvalid = 1'b1; b_rd = 1'b1;
        #1;
        n = 0;
        while (b_stall && n < 20) begin
            step();
            n++;
        end
        chk1({tag, "_complete"}, b_stall, 1'b0);
        b_rd = 1'b0; b_arready = 1'b0; b_rvalid = 1'b0;
        step();
        $display("txn B load %s addr=%h dout=%h", tag, ad, b_dout);
    endtask

    // Store with always-ready slave; reports what was seen in the WR cycle.
    task automatic a_store(input string tag, input logic [31:0] ad, input logic [1:0] sz,
                           input logic [31:0] d, output logic [31:0] wd,
                           output logic [3:0] ws, output logic saw_ar);
        int n;
        a_addr = ad; a_size = sz; a_din = d;
        a_awready = 1'b1; a_wready = 1'b1; a_wr = 1'b1;
        #1;
        step();
        wd = a_wdata; ws = a_wstrb; saw_ar = a_arvalid;
        n = 0;
        while (a_stall && n < 20) begin
            step();
            n++;
        end
        chk1({tag, "_complete"}, a_stall, 1'b0);
        a_wr = 1'b0; a_rd = 1'b0; a_awready = 1'b0; a_wready = 1'b0;
        step();
        $display("txn A store %s addr=%h wdata=%h wstrb=%b", tag, ad, wd, ws);
    endtask

    task automatic b_store(input string tag, input logic [31:0] ad, input logic [1:0] sz,
                           input logic [63:0] d, output logic [63:0] wd, output logic [7:0] ws);
        int n;
        b_addr = ad; b_size = sz; b_din = d;
        b_awready = 1'b1; b_wready = 1'b1; b_wr = 1'b1;
        #1;
        step();
        wd = b_wdata; ws = b_wstrb;
        n = 0;
        while (b_stall && n < 20) begin
            step();
            n++;
        end
        chk1({tag, "_complete"}, b_stall, 1'b0);
        b_wr = 1'b0; b_awready = 1'b0; b_wready = 1'b0;
        step();
        $display("txn B store %s addr=%h wdata=%h wstrb=%b", tag, ad, wd, ws);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd32;
        logic [3:0]  ws4;
        logic [63:0] wd64;
        logic [7:0]  ws8;
        logic        saw_ar;

        // ---- reset ----
        step(); step();
        rst_n = 1'b1;
        step();
        chk1("rst_stall", a_stall, 1'b0);
        chk1("rst_err", a_err, 1'b0);
        chk32("rst_dout", a_dout, 32'h0);
        chk1("rst_arvalid", a_arvalid, 1'b0);
        chk1("rst_rready", a_rready, 1'b0);
        chk1("rst_awvalid", a_awvalid, 1'b0);
        chk1("rst_wvalid", a_wvalid, 1'b0);
        chk64("rst_b_dout", b_dout, 64'h0);

        // ---- word load, arready in the second AR cycle ----
        a_addr = 32'h1000; a_size = 2'd2; a_sign = 1'b0; a_rd = 1'b1;
        #1;
        chk1("wl_idle_stall", a_stall, 1'b1);
        stall_cnt = a_stall ? 1 : 0;
        step();
        chk1("wl_ar1_arvalid", a_arvalid, 1'b1);
        chk32("wl_araddr", a_araddr, 32'h1000);
        stall_cnt += a_stall ? 1 : 0;
        step();
        chk1("wl_ar2_arvalid", a_arvalid, 1'b1);
        stall_cnt += a_stall ? 1 : 0;
        a_arready = 1'b1;
        step();
        chk1("wl_r_arvalid", a_arvalid, 1'b0);
        chk1("wl_r_rready", a_rready, 1'b1);
        stall_cnt += a_stall ? 1 : 0;
        a_arready = 1'b0; a_rdata = 32'hDEADBEEF; a_rvalid = 1'b1;
        step();
        chk1("wl_done_stall", a_stall, 1'b0);
        chk32("wl_dout", a_dout, 32'hDEADBEEF);
        chk1("wl_err", a_err, 1'b0);
        chk1("wl_done_rready", a_rready, 1'b0);
        chk32("wl_stall_cycles", stall_cnt, 32'd4);
        a_rd = 1'b0; a_rvalid = 1'b0;
        step();
        chk32("wl_dout_hold", a_dout, 32'hDEADBEEF);
        $display("txn A load word addr=00001000 dout=%h stall_cycles=%0d", a_dout, stall_cnt);

        // ---- sub-word loads ----
        a_load("byte_signed", 32'h1003, 2'd0, 1'b0, 32'h8000_0000);
        chk32("byte_signed_dout", a_dout, 32'hFFFF_FF80);
        a_load("byte_unsigned", 32'h1003, 2'd0, 1'b1, 32'h8000_0000);
        chk32("byte_unsigned_dout", a_dout, 32'h0000_0080);
        a_load("half_signed", 32'h1002, 2'd1, 1'b0, 32'h8001_0000);
        chk32("half_signed_dout", a_dout, 32'hFFFF_8001);
        a_load("half_unsigned", 32'h1002, 2'd1, 1'b1, 32'h8001_0000);
        chk32("half_unsigned_dout", a_dout, 32'h0000_8001);
        a_load("byte_pos", 32'h1001, 2'd0, 1'b0, 32'h0000_7F00);
        chk32("byte_pos_dout", a_dout, 32'h0000_007F);

        // ---- half store, awready in the 4th WR cycle, wready immediate ----
        a_addr = 32'h2002; a_size = 2'd1; a_din = 32'h0000_ABCD;
        a_wr = 1'b1; a_wready = 1'b1; a_awready = 1'b0;
        #1;
        chk1("hs_idle_stall", a_stall, 1'b1);
        step();
        chk1("hs_wr1_awvalid", a_awvalid, 1'b1);
        chk1("hs_wr1_wvalid", a_wvalid, 1'b1);
        chk32("hs_wdata", a_wdata, 32'hABCD_0000);
        chk32("hs_wstrb", {28'h0, a_wstrb}, 32'hC);
        chk32("hs_awaddr", a_awaddr, 32'h2000);
        awv_cnt = a_awvalid ? 1 : 0;
        a_din = 32'hFFFF_FFFF; a_addr = 32'h0;   // must be ignored mid-transaction
        step();
        chk1("hs_wr2_wvalid", a_wvalid, 1'b0);
        chk1("hs_wr2_awvalid", a_awvalid, 1'b1);
        awv_cnt += a_awvalid ? 1 : 0;
        step();
        chk32("hs_wdata_held", a_wdata, 32'hABCD_0000);
        awv_cnt += a_awvalid ? 1 : 0;
        step();
        awv_cnt += a_awvalid ? 1 : 0;
        a_awready = 1'b1;
        step();
        chk1("hs_done_awvalid", a_awvalid, 1'b0);
        chk1("hs_done_stall", a_stall, 1'b0);
        chk32("hs_awvalid_cycles", awv_cnt, 32'd4);
        a_wr = 1'b0; a_awready = 1'b0; a_wready = 1'b0;
        step();
        $display("txn A store half addr=00002002 awvalid_cycles=%0d", awv_cnt);

        // ---- byte store with memRead also high: store wins ----
        a_rd = 1'b1;
        a_store("byte_wins", 32'h3001, 2'd0, 32'h0000_005A, wd32, ws4, saw_ar);
        chk32("bw_wdata", wd32, 32'h0000_5A00);
        chk32("bw_wstrb", {28'h0, ws4}, 32'h2);
        chk1("bw_no_arvalid", saw_ar, 1'b0);
        a_store("word_st", 32'h3004, 2'd2, 32'h1234_5678, wd32, ws4, saw_ar);
        chk32("ws_wdata", wd32, 32'h1234_5678);
        chk32("ws_wstrb", {28'h0, ws4}, 32'hF);

        // ---- misaligned word load ----
        a_addr = 32'h1001; a_size = 2'd2; a_rd = 1'b1;
        #1;
        chk1("mis_idle_stall", a_stall, 1'b1);
        step();
        chk1("mis_err", a_err, 1'b1);
        chk1("mis_stall", a_stall, 1'b0);
        chk1("mis_arvalid", a_arvalid, 1'b0);
        chk32("mis_dout_kept", a_dout, 32'h0000_007F);
        a_rd = 1'b0;
        step();
        chk1("mis_err_pulse", a_err, 1'b0);
        chk1("mis_arvalid_after", a_arvalid, 1'b0);
        $display("txn A misaligned load addr=00001001");

        // ---- illegal dword size on 32-bit bus ----
        a_addr = 32'h1000; a_size = 2'd3; a_rd = 1'b1;
        #1;
        step();
        chk1("ill_err", a_err, 1'b1);
        chk1("ill_arvalid", a_arvalid, 1'b0);
        a_rd = 1'b0;
        step();
        $display("txn A illegal size load");

        // ---- misaligned half store ----
        a_addr = 32'h2001; a_size = 2'd1; a_wr = 1'b1;
        #1;
        step();
        chk1("mst_err", a_err, 1'b1);
        chk1("mst_awvalid", a_awvalid, 1'b0);
        chk1("mst_wvalid", a_wvalid, 1'b0);
        a_wr = 1'b0;
        step();
        $display("txn A misaligned store addr=00002001");

        // ---- timeout: arready held low ----
        a_addr = 32'h3000; a_size = 2'd2; a_rd = 1'b1; a_arready = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk1("tmo_arvalid_high", a_arvalid, 1'b1);
        end
        step();
        chk1("tmo_arvalid_drop", a_arvalid, 1'b0);
        chk1("tmo_err", a_err, 1'b1);
        chk32("tmo_dout", a_dout, 32'h0);
        chk1("tmo_stall", a_stall, 1'b0);
        a_rd = 1'b0;
        step();
        chk1("tmo_idle_err", a_err, 1'b0);
        chk1("tmo_idle_arvalid", a_arvalid, 1'b0);
        $display("txn A timeout load addr=00003000");

        // ---- 64-bit instance ----
        b_load("dword0", 32'h10, 2'd3, 1'b1, 64'h0123_4567_89AB_CDEF);
        chk64("dword0_dout", b_dout, 64'h0123_4567_89AB_CDEF);

        // dword load interrupted by reset in R
        b_addr = 32'h8; b_size = 2'd3; b_rd = 1'b1; b_arready = 1'b1; b_rvalid = 1'b0;
        #1;
        step();
        chk32("rr_araddr", b_araddr, 32'h8);
        step();
        chk1("rr_rready", b_rready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rr_rst_rready", b_rready, 1'b0);
        chk1("rr_rst_arvalid", b_arvalid, 1'b0);
        chk64("rr_rst_dout", b_dout, 64'h0);
        chk1("rr_rst_err", b_err, 1'b0);
        b_rd = 1'b0; b_arready = 1'b0;
        #1;
        chk1("rr_rst_stall", b_stall, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        $display("txn B reset during read");

        b_load("dword_after_rst", 32'h8, 2'd3, 1'b0, 64'hFEDC_BA98_7654_3210);
        chk64("dword_after_rst_dout", b_dout, 64'hFEDC_BA98_7654_3210);
        b_load("word_hi_signed", 32'hC, 2'd2, 1'b0, 64'h8000_0000_0000_0000);
        chk64("word_hi_signed_dout", b_dout, 64'hFFFF_FFFF_8000_0000);
        b_load("half_top_unsigned", 32'h6, 2'd1, 1'b1, 64'hBEEF_0000_0000_0000);
        chk64("half_top_unsigned_dout", b_dout, 64'h0000_0000_0000_BEEF);

        b_store("byte5", 32'h5, 2'd0, 64'h0000_0000_0000_00A5, wd64, ws8);
        chk64("b_byte5_wdata", wd64, 64'h0000_A500_0000_0000);
        chk32("b_byte5_wstrb", {24'h0, ws8}, 32'h20);
        b_store("word4", 32'h14, 2'd2, 64'h0000_0000_CAFE_F00D, wd64, ws8);
        chk64("b_word4_wdata", wd64, 64'hCAFE_F00D_0000_0000);
        chk32("b_word4_wstrb", {24'h0, ws8}, 32'hF0);

        // misaligned dword on the 64-bit bus
        b_addr = 32'h1C; b_size = 2'd3; b_rd = 1'b1;
        #1;
        step();
        chk1("b_mis_err", b_err, 1'b1);
        chk1("b_mis_arvalid", b_arvalid, 1'b0);
        chk64("b_mis_dout_kept", b_dout, 64'h0000_0000_0000_BEEF);
        b_rd = 1'b0;
        step();
        chk1("b_mis_err_pulse", b_err, 1'b0);
        $display("txn B misaligned dword load addr=0000001c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otter_axil_bridge.md
Name: otter_axil_bridge

Overview:
- Parametrised bridge from an OTTER-style memory port (addr/din/memRead/memWrite/sign/size → dout/stall) to an AXI4-Lite controller port (AR/R/AW/W channels, no B channel).
- Generalises the fixed 32-bit AXI-lite link to a DATA_WIDTH of 32 or 64.
- Generates byte-lane strobes and lane-aligns write data.
- Extracts and extends sub-word load data, detects misalignment, and aborts hung transactions with a timeout.
- One instance sits between each OTTER data/instruction port and the memory hub.

Parameters:
- ADDR_WIDTH, 32, address bits on both sides.
- DATA_WIDTH, 32, data bits; legal values are 32 and 64 only, enforced by elaboration assertion.
- TIMEOUT_CYCLES, 256, maximum cycles waiting in any bus state; 0 disables the timeout.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- addr  in  ADDR_WIDTH  byte address.
- din  in  DATA_WIDTH  store data, right-aligned.
- memRead  in  1  load request.
- memWrite  in  1  store request.
- sign  in  1  1 = unsigned load (zero-extend), 0 = sign-extend.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_WIDTH = 64).
- dout  out  DATA_WIDTH  load result, right-aligned and extended.
- stall  out  1  request not yet complete.
- err  out  1  one-cycle pulse on misalignment, illegal size or timeout.
- araddr / arvalid / arready  out/out/in  ADDR_WIDTH/1/1  read address channel.
- rdata / rvalid / rready  in/in/out  DATA_WIDTH/1/1  read data channel.
- awaddr / awvalid / awready  out/out/in  ADDR_WIDTH/1/1  write address channel.
- wdata / wvalid / wready / wstrb  out/out/in/out  DATA_WIDTH/1/1/DATA_WIDTH/8  write data channel.

Behaviour:
- Reset (RST_N low, asynchronous) sets:
  - state = IDLE;
  - all valids, rready, err = 0;
  - dout = 0; timeout counter = 0.
- Let OFF = addr[log2(DATA_WIDTH/8)-1:0].
- araddr and awaddr = addr with the OFF bits cleared; both are registered at request capture.
- State machine:
  - IDLE:
    - If memWrite is high, go to WR; memWrite wins when memRead is also high.
    - Else if memRead is high, go to AR.
    - A misaligned or illegal-size request goes to ERR instead.
    - Misaligned means: half with OFF[0]=1; word with OFF[1:0]≠0; dword with OFF≠0.
  - AR: arvalid = 1 until arready; on that handshake cycle go to R.
  - R: rready = 1; on rvalid, latch the extended result into dout and go to DONE.
  - WR:
    - awvalid and wvalid both rise on entry.
    - Each drops independently after its own handshake.
    - When both are done (same cycle or different cycles), go to DONE.
    - wdata = din << (8*OFF).
    - wstrb = ((1 << 2^size) - 1) << OFF.
  - DONE: stall = 0 for exactly one cycle, then IDLE. dout holds until the next load completes.
  - ERR: err = 1 and stall = 0 for one cycle; no bus activity; dout unchanged; then IDLE.
- stall is combinational: (memRead | memWrite) & (state ∉ {DONE, ERR}). It is therefore high in the same cycle a request appears in IDLE.
- Load extraction:
  - t = rdata >> (8*OFF), masked to 8·2^size bits.
  - Bit 8·2^size − 1 is replicated upward when sign = 0.
  - Full-width loads pass through unchanged.
- Timeout:
  - The counter increments every cycle spent in AR, R or WR and clears on entry to each of those states.
  - When it reaches TIMEOUT_CYCLES: all valids/rready drop, dout = 0, and the FSM goes to ERR.
- Inputs are sampled only in IDLE; changes to addr/din mid-transaction are ignored.
- A request still asserted in the cycle after DONE starts a new transaction; deasserting it is the core's responsibility.

Decomposition:
- Shared package otter_axil_pkg holds:
  - state enum;
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - function strb_gen(size, off);
  - function load_extend(rdata, off, size, sign);
  - function misaligned(size, off).
- One natural sub-module: otter_axil_timeout, a parametrised counter with clear/enable/expire.

Test Plan:
- Word load, DATA_WIDTH=32, addr=0x1000, arready after 2 cycles, rdata=0xDEADBEEF → araddr=0x1000; stall high 4 cycles; dout=0xDEADBEEF; err=0.
- Signed byte load at 0x1003, rdata=0x80000000, sign=0 → dout=0xFFFFFF80; with sign=1 → dout=0x00000080.
- Half store at 0x2002, din=0x0000ABCD; awready delayed 3 cycles, wready immediate → wdata=0xABCD0000, wstrb=0b1100; wvalid drops after 1 cycle, awvalid after 4; DONE follows.
- Misaligned word load at 0x1001 → err pulse 1 cycle; no arvalid; stall low in the cycle after the request.
- TIMEOUT_CYCLES=8, arready held 0 → arvalid high exactly 8 cycles then drops; err=1; dout=0; IDLE next cycle.
- DATA_WIDTH=64, dword load at 0x8, then RST_N pulsed low during R → all outputs reset immediately; rready=0; a new request after reset completes normally.
